// File: rtl/neuron_set_pkg.sv
// neuron_set_pkg: shared state encoding and post-spike reset mode constants for membrane_fire_set
package neuron_set_pkg;
  typedef enum logic [1:0] {ST_ACCUM, ST_FIRE, ST_OUT} state_t;
  localparam int RESET_ZERO = 0;
  localparam int RESET_SUBTRACT = 1;
endpackage

// File: rtl/neuron_fire_cell.sv
// neuron_fire_cell: one neuron's membrane register with threshold compare and post-spike reset
//   clk_i/reset_n_i: clock, async active-low reset
//   load_i: store update_i verbatim; fire_i: apply reset if spiking; clear_i: sync clear
//   update_i: adder result; threshold_i: firing threshold
//   membrane_o: stored membrane; spike_o: combinational (membrane >= threshold)
module neuron_fire_cell
  import neuron_set_pkg::*;
#(
  parameter int W = 17,
  parameter int RESET_MODE = RESET_ZERO
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         load_i,
  input  logic         fire_i,
  input  logic         clear_i,
  input  logic [W-1:0] update_i,
  input  logic [W-1:0] threshold_i,
  output logic [W-1:0] membrane_o,
  output logic         spike_o
);
  logic [W-1:0] r_m;
  assign spike_o = $signed(r_m) >= $signed(threshold_i);
  assign membrane_o = r_m;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_m <= '0;
    else if (clear_i) r_m <= '0;
    else if (load_i) r_m <= update_i;
    else if (fire_i && spike_o) r_m <= (RESET_MODE == RESET_SUBTRACT) ? r_m - threshold_i : '0;
endmodule

// File: rtl/membrane_fire_set.sv
// membrane_fire_set: membrane state, threshold-and-fire phase and spike handshake for one neuron set
//   clk_i/reset_n_i: clock, async active-low reset; clear_i: sync clear of all state
//   membrane_o/membrane_update_i: membranes to and results from the adder
//   accum_valid_i/weight_update_mode_i: integrate pulse and its suppress
//   timestep_end_i/threshold_i: start fire phase, firing threshold
//   spike_o/spike_valid_o/spike_ready_i: spike vector handshake
//   busy_o/overrun_o/timestep_cnt_o: status
module membrane_fire_set
  import neuron_set_pkg::*;
#(
  parameter int BIT_WIDTH_MEMBRANE = 17,
  parameter int NEURON_NUM_IN_SET = 20,
  parameter int RESET_MODE = RESET_ZERO,
  parameter int BIT_WIDTH_TIMESTEP = 8
) (
  input  logic                                            clk_i,
  input  logic                                            reset_n_i,
  output logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0] membrane_o,
  input  logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0] membrane_update_i,
  input  logic                                            accum_valid_i,
  input  logic                                            weight_update_mode_i,
  input  logic                                            timestep_end_i,
  input  logic [BIT_WIDTH_MEMBRANE-1:0]                   threshold_i,
  input  logic                                            clear_i,
  output logic [NEURON_NUM_IN_SET-1:0]                    spike_o,
  output logic                                            spike_valid_o,
  input  logic                                            spike_ready_i,
  output logic                                            busy_o,
  output logic                                            overrun_o,
  output logic [BIT_WIDTH_TIMESTEP-1:0]                   timestep_cnt_o
);
  localparam int W = BIT_WIDTH_MEMBRANE;
  localparam int N = NEURON_NUM_IN_SET;
  state_t r_state, w_next;
  logic [N-1:0] r_spike, w_spike;
  logic r_overrun;
  logic [BIT_WIDTH_TIMESTEP-1:0] r_cnt;
  logic w_accum, w_load, w_fire, w_event, w_done;
  assign w_accum = accum_valid_i & ~weight_update_mode_i;
  assign w_load = (r_state == ST_ACCUM) & w_accum & ~clear_i;
  assign w_fire = (r_state == ST_FIRE) & ~clear_i;
  assign w_done = (r_state == ST_OUT) & spike_ready_i;
  assign w_event = busy_o & (w_accum | timestep_end_i);
  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_cell
      neuron_fire_cell #(.W(W), .RESET_MODE(RESET_MODE)) u_cell (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .load_i(w_load),
        .fire_i(w_fire),
        .clear_i(clear_i),
        .update_i(membrane_update_i[W*i +: W]),
        .threshold_i(threshold_i),
        .membrane_o(membrane_o[W*i +: W]),
        .spike_o(w_spike[i])
      );
    end
  endgenerate
  always_comb begin
    w_next = r_state;
    if (clear_i) w_next = ST_ACCUM;
    else if (r_state == ST_ACCUM) w_next = timestep_end_i ? ST_FIRE : ST_ACCUM;
    else if (r_state == ST_FIRE) w_next = ST_OUT;
    else w_next = spike_ready_i ? ST_ACCUM : ST_OUT;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_state <= ST_ACCUM;
    else r_state <= w_next;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_spike <= '0;
      r_overrun <= 1'b0;
      r_cnt <= '0;
    end else if (clear_i) begin
      r_spike <= '0;
      r_overrun <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_fire) r_spike <= w_spike;
      if (w_event) r_overrun <= 1'b1;
      if (w_done) r_cnt <= r_cnt + 1'b1;
    end
  assign spike_o = r_spike;
  assign spike_valid_o = r_state == ST_OUT;
  assign busy_o = r_state != ST_ACCUM;
  assign overrun_o = r_overrun;
  assign timestep_cnt_o = r_cnt;
endmodule
